pb_debounce_capture: RTL

- Input-side responder for the board's active-low pushbuttons (KEY[3:0]).
- Synchronises and debounces the raw buttons, then latches press events in edge-capture bits.
- Exposes debounced state, edge capture and IRQ mask to the Nios II as a 4-word Avalon-MM slave. Raises a level IRQ.
- Sits between the board pins and the system interconnect, in place of a bare PIO input.

---
 rtl/pb_debounce_capture.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pb_debounce_capture.sv
// pb_debounce_capture
//   Input-side responder for active-low pushbuttons. Each raw pin passes through a
//   two-flop synchroniser and a per-bit debounce counter. Press events (debounced
//   level 1->0) are latched in W1C edge-capture bits. State, edge capture and the
//   IRQ mask are exposed as a 4-word Avalon-MM slave with fixed 1-cycle read
//   latency and no waitrequest. A registered level IRQ is raised while any
//   enabled capture bit is set.
//
//   Optional feature macro: PB_RELEASE_CAPTURE_EN
//     Defined   : word 3 is a W1C release-capture register, set when the
//                 debounced level goes 0->1, and it also feeds the IRQ.
//     Undefined : word 3 reads 0, writes to it are ignored, and no release
//                 flops are built.
//
//   Ports
//     clk_clk        system clock
//     reset_reset_n  asynchronous active-low reset
//     btn_n          raw button pins, active-low, asynchronous to clk_clk
//     avs_address    word address (0 STATE, 1 EDGE, 2 MASK, 3 RELEASE)
//     avs_read       read strobe
//     avs_write      write strobe
//     avs_writedata  write data
//     avs_readdata   registered read data, valid the cycle after avs_read
//     irq            registered level interrupt

module pb_debounce_capture #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] btn_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_n_q, stable_n_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] irq_src;
    logic [31:0]      rd_word;

    assign wdata = avs_writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^avs_writedata[31:WIDTH];
    end

    // Debounce: any disagreement must persist for DEBOUNCE_CYCLES consecutive
    // cycles; a single agreeing cycle restarts the count.
    always_comb begin
        stable_n_d = stable_n_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_n_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_n_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copy of the debounced level turns a level change into a one-cycle
    // event in the cycle after stable_n changes.
    assign press = stable_dly_q & ~stable_n_q;

    // W1C with set-wins: the event OR is applied after the clear.
    always_comb begin
        edge_cap_d = edge_cap_q;
        if (avs_write && avs_address == 2'd1) begin
            edge_cap_d = edge_cap_q & ~wdata;
        end
        edge_cap_d = edge_cap_d | press;
    end

    always_comb begin
        mask_d = mask_q;
        if (avs_write && avs_address == 2'd2) begin
            mask_d = wdata;
        end
    end

`ifdef PB_RELEASE_CAPTURE_EN
    logic [WIDTH-1:0] rel_q, rel_d;
    logic [WIDTH-1:0] rel_evt;

    assign rel_evt = ~stable_dly_q & stable_n_q;

    always_comb begin
        rel_d = rel_q;
        if (avs_write && avs_address == 2'd3) begin
            rel_d = rel_q & ~wdata;
        end
        rel_d = rel_d | rel_evt;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rel_q <= '0;
        end else begin
            rel_q <= rel_d;
        end
    end

    assign irq_src = (edge_cap_q | rel_q) & mask_q;
`else
    assign irq_src = edge_cap_q & mask_q;
`endif

    // Read mux uses pre-write register values, so a same-cycle write is not seen.
    always_comb begin
        rd_word = '0;
        case (avs_address)
            2'd0: rd_word[WIDTH-1:0] = ~stable_n_q;
            2'd1: rd_word[WIDTH-1:0] = edge_cap_q;
            2'd2: rd_word[WIDTH-1:0] = mask_q;
`ifdef PB_RELEASE_CAPTURE_EN
            2'd3: rd_word[WIDTH-1:0] = rel_q;
`endif
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        readdata_d = readdata_q;
        if (avs_read) begin
            readdata_d = rd_word;
        end
        irq_d = |irq_src;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            stable_n_q   <= '1;
            stable_dly_q <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            edge_cap_q   <= '0;
            mask_q       <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            sync1_q      <= btn_n;
            sync2_q      <= sync1_q;
            stable_n_q   <= stable_n_d;
            stable_dly_q <= stable_n_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            edge_cap_q   <= edge_cap_d;
            mask_q       <= mask_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;

endmodule
